// File: rtl/spi_reg_writer.sv
// SPI mode-0 target that accepts 16-bit write frames and drives five 8-bit PWM config registers.
// Optional readback of registers on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_writer #(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] NUM_REGS_L = 7'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic [SYNC_STAGES-1:0] vld_sync_q,  vld_sync_d;
    logic                   sclk_s, copi_s, ncs_s, vld_s;

    logic sclk_prev_q, sclk_prev_d;
    logic ncs_prev_q,  ncs_prev_d;
    logic copi_q,      copi_d;
    logic sclk_rise_q, sclk_rise_d;
    logic sclk_fall_q, sclk_fall_d;
    logic ncs_rise_q,  ncs_rise_d;
    logic ncs_fall_q,  ncs_fall_d;
    logic armed_q,     armed_d;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [15:0]     sr_q, sr_d;
    logic [4:0][7:0] regs_q, regs_d;
    logic            frame_err_q, frame_err_d;

    logic clear_s, shift_en_s, wr_s, err_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign vld_s  = vld_sync_q[SYNC_STAGES-1];

    // Synchronizers, edge detection and registered event pulses
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        vld_sync_d  = {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
        ncs_prev_d  = ncs_s;
        copi_d      = copi_s;
        sclk_rise_d = sclk_s & ~sclk_prev_q;
        sclk_fall_d = ~sclk_s & sclk_prev_q;
        ncs_rise_d  = ncs_s & ~ncs_prev_q;
        // A falling ncs only counts once a genuine high level has passed through the synchronizer.
        ncs_fall_d  = ~ncs_s & ncs_prev_q & armed_q;
        armed_d     = armed_q | (vld_s & ncs_s);
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ncs_fall_q) state_d = ST_SHIFT; else state_d = ST_IDLE;
            ST_SHIFT:  if (ncs_rise_q) state_d = ST_COMMIT; else state_d = ST_SHIFT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; ncs_prev_q is the ncs level aligned with the event pulses
    always_comb begin
        clear_s    = (state_q == ST_IDLE) && ncs_fall_q;
        shift_en_s = (state_q == ST_SHIFT) && sclk_rise_q && !ncs_prev_q;
        wr_s       = (state_q == ST_COMMIT) && (cnt_q == 5'd16) && sr_q[15] && (sr_q[14:8] < NUM_REGS_L);
        err_s      = (state_q == ST_COMMIT) && (cnt_q != 5'd16);
    end

    // Shift register, saturating bit counter and register file
    always_comb begin
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        regs_d      = regs_q;
        frame_err_d = err_s;
        if (clear_s) begin
            cnt_d = 5'd0;
            sr_d  = 16'd0;
        end else if (shift_en_s) begin
            sr_d = {sr_q[14:0], copi_q};
            if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1; else cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q;
        end
        for (int i = 0; i < 5; i++) begin
            if (wr_s && (i < NUM_REGS) && (sr_q[14:8] == 7'(i))) regs_d[i] = sr_q[7:0];
            else regs_d[i] = regs_q[i];
        end
    end

    // Main state flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            vld_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            copi_q      <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            sr_q        <= 16'd0;
            regs_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            vld_sync_q  <= vld_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            copi_q      <= copi_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            ncs_rise_q  <= ncs_rise_d;
            ncs_fall_q  <= ncs_fall_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            regs_q      <= regs_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q, tx_d;
    logic       cipo_q, cipo_d;
    logic [6:0] rd_addr_s;
    logic [7:0] rd_data_s;

    // Transmit shifter: load after bit 8 of a read frame, advance on falls after bit 9 is sampled
    always_comb begin
        rd_addr_s = {sr_q[5:0], copi_q};
        rd_data_s = 8'd0;
        for (int i = 0; i < 5; i++) begin
            if ((i < NUM_REGS) && (rd_addr_s == 7'(i))) rd_data_s = regs_q[i];
            else rd_data_s = rd_data_s;
        end
        if (clear_s) tx_d = 8'd0;
        else if (shift_en_s && (cnt_q == 5'd7) && !sr_q[6]) tx_d = rd_data_s;
        else if ((state_q == ST_SHIFT) && sclk_fall_q && (cnt_q >= 5'd9)) tx_d = {tx_q[6:0], 1'b0};
        else tx_d = tx_q;
        if (!ncs_s && (state_d == ST_SHIFT)) cipo_d = tx_d[7];
        else cipo_d = 1'b0;
    end

    // Readback flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= 8'd0;
            cipo_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            cipo_q <= cipo_d;
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign frame_err       = frame_err_q;

endmodule

// File: doc/spi_reg_writer.md
Name: spi_reg_writer

Overview:
- SPI target that receives 16-bit write frames from an external controller and drives the five configuration registers read by the PWM peripheral.
- Registers: output-enable [15:0], PWM-enable [15:0], and duty cycle.
- Sits between the dedicated input pins (sclk/copi/ncs) and the PWM peripheral's register inputs.
- SPI pins are asynchronous to clk; all sampling goes through synchronizers.

Parameters:
- NUM_REGS, 5, number of implemented register addresses (0..NUM_REGS-1); max 5.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (>=2).

Ports:
- clk  input  1  system clock; sole clock of the block.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous.
- copi  input  1  SPI data in, MSB first.
- ncs  input  1  SPI chip select, active low.
- cipo  output  1  SPI data out (readback; see Optional Feature).
- en_reg_out_7_0  output  8  register 0x00.
- en_reg_out_15_8  output  8  register 0x01.
- en_reg_pwm_7_0  output  8  register 0x02.
- en_reg_pwm_15_8  output  8  register 0x03.
- pwm_duty_cycle  output  8  register 0x04.
- frame_err  output  1  one-clk pulse when a frame ends with bit count != 16.

Behaviour:
- Reset:
  - All five registers, frame_err, cipo, shift register and bit counter go to 0 asynchronously.
  - All synchronizers are preset to idle levels: ncs=1, sclk=0, copi=0.
- Synchronization and edge detection:
  - sclk, copi and ncs each pass through SYNC_STAGES flops, then one edge-detect flop.
  - Events are evaluated on the synchronized signals only.
- Frame format, 16 bits MSB first:
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
- FSM IDLE:
  - Synchronized ncs falling edge -> SHIFT.
  - On entry, bit counter and shift register are cleared.
- FSM SHIFT:
  - On each synchronized sclk rising edge while ncs low: shift copi into the LSB and increment the counter.
  - The counter saturates at 17, so any frame longer than 16 bits is detected.
  - Synchronized ncs rising edge -> COMMIT.
- FSM COMMIT (exactly one clk) evaluates the frame as follows, then returns to IDLE:
  - If count==16, R/W=1 and address<NUM_REGS: write data to the addressed register.
  - If count==16 and R/W=0: no register change.
  - If count==16 and address>=NUM_REGS: frame dropped silently, no frame_err.
  - If count!=16 (including 0 and >16): frame dropped, frame_err high for this cycle.
- Timing:
  - Register update is visible at the clk edge ending COMMIT, i.e. SYNC_STAGES+3 clk edges after ncs rises at the pin.
  - With defaults: 5 edges.
- Input rate constraint: sclk frequency <= clk/6 (high and low each >= 3 clk periods). Faster input is unsupported; no detection required.
- Simultaneous sclk rise and ncs rise in the same synchronized cycle: ncs takes priority; that sclk edge is not counted.
- Other protocol rules:
  - ncs low at reset release: treated as idle until a full high->low transition is seen.
  - Back-to-back frames: ncs may fall again one synchronized cycle after COMMIT; IDLE accepts it.
- Register outputs are direct flop outputs (no combinational path from pins).
- cipo is 0 whenever ncs (synchronized) is high.

Optional Feature:
- Macro SPI_READBACK_EN.
- Defined (read frames):
  - After the 8th bit of a frame with R/W=0, load the addressed register (0 if address>=NUM_REGS) into an 8-bit transmit shifter.
  - cipo presents bit7 immediately, then shifts one bit per synchronized sclk falling edge through bits 8..15.
  - Write frames keep cipo at 0.
- Undefined: cipo tied to 0 and the transmit shifter is not synthesized.
- Write behaviour is identical either way.

Test Plan:
- Write 0x8455 (addr 0x04, data 0x55) at sclk=clk/8 -> pwm_duty_cycle=0x55 at 5 clk after ncs rise; other registers stay 0; frame_err stays 0.
- Five writes 0x80F0, 0x810F, 0x82AA, 0x83CC, 0x8480 back-to-back -> registers read F0, 0F, AA, CC, 80.
- Write 0x8A11 (addr 0x0A) -> all registers unchanged; no frame_err. Read frame 0x02xx -> no register change.
- 15-bit frame, then a 17-bit frame, each carrying 0x84FF -> pwm_duty_cycle unchanged; frame_err pulses exactly once per frame (1 clk).
- Assert rst mid-frame after 9 bits, release, then send 0x8033 -> all registers 0 after reset; en_reg_out_7_0=0x33 after the frame.
- With SPI_READBACK_EN: write 0x823C, then read frame 0x0200 -> cipo shifts 0,0,1,1,1,1,0,0 across bits 8..15. Without it, cipo stays 0 throughout.
